// File: rtl/fab_add32_pipe_if.sv
// ---------------------------------------------------------------------------
// fab_add32_pipe_if
// Handshake bundle for the pipelined fabric adder.
//   Upstream side   : A, B, CI, in_valid (to adder), in_ready (from adder)
//   Downstream side : Y, out_valid (from adder), out_ready (to adder)
//   Optional        : CO, OVF (from adder), present only when FAB_ADD_OVF_EN
//                     is defined
// Modports:
//   master - the fabric side driving operands and taking results
//   slave  - the adder itself
// ---------------------------------------------------------------------------
interface fab_add32_pipe_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  CI;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] Y;
  logic                  out_valid;
  logic                  out_ready;
`ifdef FAB_ADD_OVF_EN
  logic                  CO;
  logic                  OVF;
`endif

  modport master (
    output A, B, CI, in_valid, out_ready,
`ifdef FAB_ADD_OVF_EN
    input  CO, OVF,
`endif
    input  in_ready, Y, out_valid
  );

  modport slave (
    input  A, B, CI, in_valid, out_ready,
`ifdef FAB_ADD_OVF_EN
    output CO, OVF,
`endif
    output in_ready, Y, out_valid
  );
endinterface

// File: rtl/fab_add32_pipe.sv
// ---------------------------------------------------------------------------
// fab_add32_pipe
// Two-stage carry-split adder with valid/ready on both sides. Stage 1 adds
// the low SPLIT bits plus CI and registers the high operand halves; stage 2
// finishes the high half with the registered low carry and registers Y,
// masked to Y_WIDTH bits. The carry out of the datapath MSB is discarded.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fab_add32_pipe_if.slave (A, B, CI, in_valid, in_ready,
//          Y, out_valid, out_ready, and CO/OVF when enabled)
// Configuration macro: FAB_ADD_OVF_EN
//   defined   -> registered CO (carry out of bit Y_WIDTH-1) and OVF
//                (signed overflow at bit Y_WIDTH-1) follow Y
//   undefined -> no CO/OVF ports or registers
// ---------------------------------------------------------------------------
module fab_add32_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int SPLIT      = 16,
  parameter int Y_WIDTH    = 32
) (
  input  logic           clk,
  input  logic           rst,
  fab_add32_pipe_if.slave bus
);

  localparam int HI_WIDTH = DATA_WIDTH - SPLIT;
  localparam logic [DATA_WIDTH-1:0] Y_MASK =
    {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - Y_WIDTH);

  logic                  s1_valid_r;
  logic                  s2_valid_r;
  logic                  s1_en_s;
  logic                  s2_en_s;
  logic [HI_WIDTH-1:0]   s1_a_hi_r;
  logic [HI_WIDTH-1:0]   s1_b_hi_r;
  logic [SPLIT-1:0]      s1_lo_sum_r;
  logic                  s1_lo_carry_r;
  logic [SPLIT:0]        lo_full_s;
  logic [DATA_WIDTH-1:0] y_next_s;
  logic [DATA_WIDTH-1:0] y_r;

`ifdef FAB_ADD_OVF_EN
  logic [HI_WIDTH:0]     hi_full_s;
  logic [DATA_WIDTH:0]   sum_full_s;
  logic [DATA_WIDTH:0]   a_ext_s;
  logic [DATA_WIDTH:0]   b_ext_s;
  // bit 1: operand bit Y_WIDTH (0 past the MSB), bit 0: operand bit Y_WIDTH-1
  logic [1:0]            s1_a_top_r;
  logic [1:0]            s1_b_top_r;
  logic                  co_next_s;
  logic                  ovf_next_s;
  logic                  co_r;
  logic                  ovf_r;
`else
  logic [HI_WIDTH-1:0]   hi_sum_s;
`endif

  // Stage enables: a stage may load when it is empty or its content moves on.
  always_comb begin
    s2_en_s = !s2_valid_r || bus.out_ready;
    s1_en_s = !s1_valid_r || s2_en_s;
  end

  // Low-half sum of the incoming operands; bit SPLIT is the carry into the high half.
  always_comb begin
    lo_full_s = {1'b0, bus.A[SPLIT-1:0]} + {1'b0, bus.B[SPLIT-1:0]} +
                {{SPLIT{1'b0}}, bus.CI};
  end

`ifdef FAB_ADD_OVF_EN
  // High-half completion plus carry/overflow derivation on the unmasked sum.
  always_comb begin
    a_ext_s    = {1'b0, bus.A};
    b_ext_s    = {1'b0, bus.B};
    hi_full_s  = {1'b0, s1_a_hi_r} + {1'b0, s1_b_hi_r} +
                 {{HI_WIDTH{1'b0}}, s1_lo_carry_r};
    sum_full_s = {hi_full_s, s1_lo_sum_r};
    y_next_s   = sum_full_s[DATA_WIDTH-1:0] & Y_MASK;
    // Carry into bit Y_WIDTH recovered from the sum bit and both operand bits.
    co_next_s  = sum_full_s[Y_WIDTH] ^ s1_a_top_r[1] ^ s1_b_top_r[1];
    ovf_next_s = (s1_a_top_r[0] == s1_b_top_r[0]) &&
                 (sum_full_s[Y_WIDTH-1] != s1_a_top_r[0]);
  end
`else
  // High-half completion; the carry out of the MSB is dropped by truncation.
  always_comb begin
    hi_sum_s = s1_a_hi_r + s1_b_hi_r + HI_WIDTH'(s1_lo_carry_r);
    y_next_s = {hi_sum_s, s1_lo_sum_r} & Y_MASK;
  end
`endif

  // Stage 1 register: valid follows in_valid when enabled; data loads only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r    <= 1'b0;
      s1_a_hi_r     <= {HI_WIDTH{1'b0}};
      s1_b_hi_r     <= {HI_WIDTH{1'b0}};
      s1_lo_sum_r   <= {SPLIT{1'b0}};
      s1_lo_carry_r <= 1'b0;
`ifdef FAB_ADD_OVF_EN
      s1_a_top_r    <= 2'b00;
      s1_b_top_r    <= 2'b00;
`endif
    end else begin
      if (s1_en_s) begin
        s1_valid_r <= bus.in_valid;
      end
      if (s1_en_s && bus.in_valid) begin
        s1_a_hi_r     <= bus.A[DATA_WIDTH-1:SPLIT];
        s1_b_hi_r     <= bus.B[DATA_WIDTH-1:SPLIT];
        s1_lo_sum_r   <= lo_full_s[SPLIT-1:0];
        s1_lo_carry_r <= lo_full_s[SPLIT];
`ifdef FAB_ADD_OVF_EN
        s1_a_top_r    <= {a_ext_s[Y_WIDTH], a_ext_s[Y_WIDTH-1]};
        s1_b_top_r    <= {b_ext_s[Y_WIDTH], b_ext_s[Y_WIDTH-1]};
`endif
      end
    end
  end

  // Stage 2 register: holds Y (and CO/OVF) stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      y_r        <= {DATA_WIDTH{1'b0}};
`ifdef FAB_ADD_OVF_EN
      co_r       <= 1'b0;
      ovf_r      <= 1'b0;
`endif
    end else begin
      if (s2_en_s) begin
        s2_valid_r <= s1_valid_r;
      end
      if (s2_en_s && s1_valid_r) begin
        y_r   <= y_next_s;
`ifdef FAB_ADD_OVF_EN
        co_r  <= co_next_s;
        ovf_r <= ovf_next_s;
`endif
      end
    end
  end

  assign bus.in_ready  = s1_en_s;
  assign bus.Y         = y_r;
  assign bus.out_valid = s2_valid_r;
`ifdef FAB_ADD_OVF_EN
  assign bus.CO        = co_r;
  assign bus.OVF       = ovf_r;
`endif

endmodule

// File: tb/tb_fab_add32_pipe.sv
// ---------------------------------------------------------------------------
// tb_fab_add32_pipe
// Directed bench for fab_add32_pipe: a default instance (Y_WIDTH=32) and a
// narrow instance (Y_WIDTH=8) share clock and reset. Inputs change and
// outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_fab_add32_pipe;

  logic clk;
  logic rst;

  fab_add32_pipe_if #(.DATA_WIDTH(32)) bus  ();
  fab_add32_pipe_if #(.DATA_WIDTH(32)) bus8 ();

  fab_add32_pipe #(.DATA_WIDTH(32), .SPLIT(16), .Y_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fab_add32_pipe #(.DATA_WIDTH(32), .SPLIT(16), .Y_WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Hand-computed vectors: tab_y = (tab_a + tab_b + tab_c) mod 2^32
  logic [31:0] tab_a [8] = '{32'h00000001, 32'h12345678, 32'h0000FFFF, 32'h80000000,
                             32'hDEADBEEF, 32'h7FFFFFFF, 32'hAAAAAAAA, 32'hFFFF0000};
  logic [31:0] tab_b [8] = '{32'h00000002, 32'h11111111, 32'h0000FFFF, 32'h80000000,
                             32'h00000000, 32'h00000001, 32'h55555555, 32'h00010000};
  logic        tab_c [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] tab_y [8] = '{32'h00000003, 32'h23456789, 32'h0001FFFF, 32'h00000000,
                             32'hDEADBEF0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single item through the default instance, checking the two-cycle latency.
  task automatic one_shot(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic [31:0] exp_y,
                          input logic exp_co, input logic exp_ovf);
    bus.A = a; bus.B = b; bus.CI = ci; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check_val({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check_val({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
    step();
    check_val({tag, "_lat2_valid"}, 64'(bus.out_valid), 64'd1);
    check_val({tag, "_y"}, 64'(bus.Y), 64'(exp_y));
`ifdef FAB_ADD_OVF_EN
    check_val({tag, "_co"}, 64'(bus.CO), 64'(exp_co));
    check_val({tag, "_ovf"}, 64'(bus.OVF), 64'(exp_ovf));
`else
    if (exp_co === 1'bx || exp_ovf === 1'bx) $display("note: %s has undefined flag expectation", tag);
`endif
    step();
    check_val({tag, "_drain_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_q [$];
    int sent;
    int got;

    bus.A = 32'h0; bus.B = 32'h0; bus.CI = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus8.A = 32'h0; bus8.B = 32'h0; bus8.CI = 1'b0; bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;

    // 1. Reset held with random traffic: outputs stay cleared.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.A = $urandom; bus.B = $urandom; bus.CI = 1'($urandom_range(1)); bus.in_valid = 1'b1;
      step();
      check_val("rst_y", 64'(bus.Y), 64'd0);
      check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst_y8", 64'(bus8.Y), 64'd0);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_val("rel_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rel_out_valid", 64'(bus.out_valid), 64'd0);

    // 2. Low-half carry crossing SPLIT.
    one_shot("split_carry", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);
    // 3. Wrap-around with carry-in.
    one_shot("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b1, 1'b0);
    // Signed overflow: 0x7FFFFFFF + 1.
    one_shot("sovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);

    // 4. Back-to-back stream of 8, no bubbles, in order.
    for (int i = 0; i < 10; i++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = (i < 8);
      if (i < 8) begin
        bus.A = tab_a[i]; bus.B = tab_b[i]; bus.CI = tab_c[i];
      end
      #1;
      if (i < 8) check_val("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      if (i >= 2) begin
        check_val("b2b_out_valid", 64'(bus.out_valid), 64'd1);
        check_val("b2b_y", 64'(bus.Y), 64'(tab_y[i-2]));
      end
      step();
    end
    check_val("b2b_end_valid", 64'(bus.out_valid), 64'd0);

    // 5. Stall for 5 cycles mid-stream: Y held, in_ready low after 2 items.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      bus.out_ready = !(c >= 2 && c < 7);
      bus.in_valid  = (sent < 5);
      bus.A  = tab_a[(sent < 5) ? sent : 0];
      bus.B  = tab_b[(sent < 5) ? sent : 0];
      bus.CI = tab_c[(sent < 5) ? sent : 0];
      #1;
      if (c >= 2 && c < 7) begin
        check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check_val("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check_val("stall_inflight", 64'(exp_q.size()), 64'd2);
        if (exp_q.size() > 0) check_val("stall_y_hold", 64'(bus.Y), 64'(exp_q[0]));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() > 0) check_val("stall_stream_y", 64'(bus.Y), 64'(exp_q.pop_front()));
        else check_val("stall_extra_item", 64'(bus.Y), 64'hDEAD_0000_0000_0000);
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(tab_y[sent]);
        sent++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_val("stall_delivered", 64'(got), 64'd5);
    check_val("stall_accepted", 64'(sent), 64'd5);
    check_val("stall_end_valid", 64'(bus.out_valid), 64'd0);

    // 6. Narrow result width: upper bits of the sum are masked off.
    bus8.A = 32'h123456F0; bus8.B = 32'h00000020; bus8.CI = 1'b0;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    step();
    check_val("y8_valid", 64'(bus8.out_valid), 64'd1);
    check_val("y8_y", 64'(bus8.Y), 64'h0000_0010);
`ifdef FAB_ADD_OVF_EN
    check_val("y8_co", 64'(bus8.CO), 64'd1);
    check_val("y8_ovf", 64'(bus8.OVF), 64'd0);
`endif
    step();

    // Reset mid-stream: out_valid falls without waiting for a clock edge.
    bus.A = tab_a[0]; bus.B = tab_b[0]; bus.CI = tab_c[0];
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    step();
    check_val("mid_pre_valid", 64'(bus.out_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check_val("mid_rst_y", 64'(bus.Y), 64'd0);
    step();
    rst = 1'b0;
    bus.A = tab_a[1]; bus.B = tab_b[1]; bus.CI = tab_c[1];
    bus.in_valid = 1'b1;
    #1;
    check_val("post_rst_valid", 64'(bus.out_valid), 64'd0);
    step();
    bus.in_valid = 1'b0;
    check_val("post_lat1_valid", 64'(bus.out_valid), 64'd0);
    step();
    check_val("post_lat2_valid", 64'(bus.out_valid), 64'd1);
    check_val("post_y", 64'(bus.Y), 64'(tab_y[1]));
    step();
    check_val("post_drain_valid", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Time limit: the directed sequence above finishes long before this.
  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish by 50000");
    $fatal(1, "time limit reached");
  end

endmodule
